// File: rtl/chip_pkg.sv
// chip_pkg: shared types and constants for the 7402 quad 2-input NOR emulator.
// Holds the emulator state enum, the per-gate fault enum, the delay ceiling
// and the gate evaluation helper used by chip_7402_emu.
package chip_pkg;

    localparam int MAX_DELAY = 4;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } emu_state_e;

    typedef enum logic [1:0] {
        FT_NONE   = 2'b00,
        FT_STUCK0 = 2'b01,
        FT_STUCK1 = 2'b10,
        FT_INVERT = 2'b11
    } fault_type_e;

    // One gate's output: a healthy gate is NOR, faults replace that result.
    function automatic logic gate_eval(input logic a, input logic b, input fault_type_e ft);
        logic y;
        case (ft)
            FT_NONE:   y = ~(a | b);
            FT_STUCK0: y = 1'b0;
            FT_STUCK1: y = 1'b1;
            FT_INVERT: y = a | b;
            default:   y = ~(a | b);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/chip_7402_emu_if.sv
// chip_7402_emu_if: pin-level and fault-injection signals of the 7402 emulator.
// The master side drives the gate inputs, power enable and fault strobe;
// the slave side (the emulator) drives the gate outputs and status.
interface chip_7402_emu_if;

    logic       Enable;
    logic       Pin2, Pin3, Pin5, Pin6, Pin8, Pin9, Pin11, Pin12;
    logic       Pin1, Pin4, Pin10, Pin13;
    logic       Fault_Load;
    logic [1:0] Fault_Gate;
    logic [1:0] Fault_Type;
    logic       Fault_Ack;
    logic       Active;
    logic [7:0] Vec_Count;

    modport master (
        output Enable,
        output Pin2, Pin3, Pin5, Pin6, Pin8, Pin9, Pin11, Pin12,
        output Fault_Load, Fault_Gate, Fault_Type,
        input  Pin1, Pin4, Pin10, Pin13,
        input  Fault_Ack, Active, Vec_Count
    );

    modport slave (
        input  Enable,
        input  Pin2, Pin3, Pin5, Pin6, Pin8, Pin9, Pin11, Pin12,
        input  Fault_Load, Fault_Gate, Fault_Type,
        output Pin1, Pin4, Pin10, Pin13,
        output Fault_Ack, Active, Vec_Count
    );

endinterface

// File: rtl/chip_emu_delay_line.sv
// chip_emu_delay_line: 4-bit wide, DEPTH-deep shift register that models the
// gate propagation delay. A flush discards everything already in flight; the
// word presented on the flush edge is current data and is kept, so the line
// holds only post-flush samples and is full again DEPTH cycles later.
module chip_emu_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    logic [DEPTH-1:0][3:0] stage_q;
    logic [DEPTH-1:0][3:0] stage_d;

    // Next contents: shift din in, or drop older stages on a flush
    always_comb begin
        stage_d = {DEPTH{4'b0000}};
        if (flush) begin
            stage_d[0] = din;
        end else begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Shift register storage with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= {DEPTH{4'b0000}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/chip_7402_emu.sv
// chip_7402_emu: cycle-based emulator of a 7402 quad 2-input NOR package.
// Power sequencing Off -> Settle -> Active, DELAY-cycle output latency,
// input-vector change counter, and optional per-gate fault injection built
// only when the macro CHIP_EMU_FAULT_EN is defined.
module chip_7402_emu
    import chip_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    chip_7402_emu_if.slave  bus
);

    // Out-of-range DELAY values are clamped into 1..MAX_DELAY.
    localparam int         DEPTH       = (DELAY < 1) ? 1 : ((DELAY > MAX_DELAY) ? MAX_DELAY : DELAY);
    localparam logic [1:0] SETTLE_LAST = 2'(DEPTH - 1);

    emu_state_e      state_q, state_d;
    logic [1:0]      settle_cnt_q, settle_cnt_d;
    logic [7:0]      prev_vec_q, prev_vec_d;
    logic [7:0]      vec_count_q, vec_count_d;
    logic [3:0]      pin_q, pin_d;
    logic            active_q, active_d;
    logic [7:0]      vec_s;
    logic            flush_s;
    logic [3:0]      gate_y_s;
    logic [3:0]      dl_out_s;
    logic [3:0][1:0] fault_s;

    // Gate inputs in pin order: bits [2g+1:2g] are the A/B pair of gate g.
    assign vec_s = {bus.Pin12, bus.Pin11, bus.Pin9, bus.Pin8,
                    bus.Pin6,  bus.Pin5,  bus.Pin3, bus.Pin2};

`ifdef CHIP_EMU_FAULT_EN
    logic [3:0][1:0] fault_q, fault_d;
    logic            ack_q, ack_d;

    // Fault table update: a strobe overwrites the selected gate's entry
    always_comb begin
        fault_d = fault_q;
        ack_d   = 1'b0;
        if (bus.Fault_Load) begin
            fault_d[bus.Fault_Gate] = bus.Fault_Type;
            ack_d                   = 1'b1;
        end else begin
            ack_d = 1'b0;
        end
    end

    // Fault table and acknowledge registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fault_q <= {4{2'b00}};
            ack_q   <= 1'b0;
        end else begin
            fault_q <= fault_d;
            ack_q   <= ack_d;
        end
    end

    assign fault_s       = fault_q;
    assign bus.Fault_Ack = ack_q;
`else
    assign fault_s       = {4{2'b00}};
    assign bus.Fault_Ack = 1'b0;
`endif

    // Evaluate the four gates (with faults) on the live inputs
    always_comb begin
        gate_y_s = 4'b0000;
        for (int g = 0; g < 4; g++) begin
            gate_y_s[g] = gate_eval(vec_s[2*g], vec_s[2*g+1], fault_type_e'(fault_s[g]));
        end
    end

    chip_emu_delay_line #(
        .DEPTH (DEPTH)
    ) u_delay_line (
        .clk   (Clk),
        .rst_n (Reset),
        .flush (flush_s),
        .din   (gate_y_s),
        .dout  (dl_out_s)
    );

    // Power FSM, settle timer, vector-change counter and output gating
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        vec_count_d  = vec_count_q;
        flush_s      = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (bus.Enable) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 2'd0;
                    vec_count_d  = 8'd0;
                    flush_s      = 1'b1;
                end else begin
                    state_d = ST_OFF;
                end
            end
            ST_SETTLE: begin
                if (!bus.Enable) begin
                    state_d = ST_OFF;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_ACTIVE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 2'd1;
                end
            end
            ST_ACTIVE: begin
                if (!bus.Enable) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_ACTIVE;
                end
                // Only changes seen while already Active count, so an input
                // change on the Settle->Active edge is never counted.
                if ((vec_s != prev_vec_q) && (vec_count_q != 8'hFF)) begin
                    vec_count_d = vec_count_q + 8'd1;
                end else begin
                    vec_count_d = vec_count_q;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
        prev_vec_d = vec_s;
        active_d   = (state_d == ST_ACTIVE);
        pin_d      = active_d ? dl_out_s : 4'b0000;
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= ST_OFF;
            settle_cnt_q <= 2'd0;
            prev_vec_q   <= 8'h00;
            vec_count_q  <= 8'h00;
            pin_q        <= 4'b0000;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            prev_vec_q   <= prev_vec_d;
            vec_count_q  <= vec_count_d;
            pin_q        <= pin_d;
            active_q     <= active_d;
        end
    end

    assign bus.Pin1      = pin_q[0];
    assign bus.Pin4      = pin_q[1];
    assign bus.Pin10     = pin_q[2];
    assign bus.Pin13     = pin_q[3];
    assign bus.Active    = active_q;
    assign bus.Vec_Count = vec_count_q;

endmodule

// File: tb/tb_chip_7402_emu.sv
// tb_chip_7402_emu: self-checking bench for chip_7402_emu with DELAY=2.
// Vector tables carry hand-computed pin values; a queue scoreboard lines
// each expected value up with the output DELAY cycles later. Fault cases
// expect injected behaviour only when CHIP_EMU_FAULT_EN is defined.
module tb_chip_7402_emu;

    localparam int DELAY = 2;

`ifdef CHIP_EMU_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] vec;
        logic [3:0] pins;
    } vec_rec_t;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    chip_7402_emu_if bus ();

    chip_7402_emu #(
        .DELAY (DELAY)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_vec(input logic [7:0] v);
        bus.Pin2  = v[0];
        bus.Pin3  = v[1];
        bus.Pin5  = v[2];
        bus.Pin6  = v[3];
        bus.Pin8  = v[4];
        bus.Pin9  = v[5];
        bus.Pin11 = v[6];
        bus.Pin12 = v[7];
    endtask

    function automatic logic [3:0] get_pins();
        return {bus.Pin13, bus.Pin10, bus.Pin4, bus.Pin1};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_active(input string nm);
        int n = 0;
        while (bus.Active !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check(nm, 8'(bus.Active), 8'h01);
    endtask

    // Drive a vector table through the scoreboard; returns input changes seen.
    task automatic stream(input string nm, input vec_rec_t recs[$], input logic [7:0] prev_in,
                          output int changes);
        logic [3:0] q[$];
        logic [3:0] e;
        logic [7:0] prev;
        changes = 0;
        prev    = prev_in;
        foreach (recs[i]) begin
            drive_vec(recs[i].vec);
            q.push_back(recs[i].pins);
            if (recs[i].vec != prev) changes++;
            prev = recs[i].vec;
            tick();
            if (q.size() > DELAY) begin
                e = q.pop_front();
                check(nm, 8'(get_pins()), 8'(e));
            end
        end
        while (q.size() > 0) begin
            tick();
            e = q.pop_front();
            check(nm, 8'(get_pins()), 8'(e));
        end
    endtask

    // Inject one fault while Active and follow it through the delay line.
    task automatic fault_case(input string nm, input logic [1:0] g, input logic [1:0] t,
                              input logic [7:0] v, input logic [3:0] pins_pre, input logic [3:0] pins_flt);
        logic [3:0] flt_eff;
        flt_eff = FAULT_EN ? pins_flt : pins_pre;
        drive_vec(v);
        repeat (DELAY + 1) tick();
        check({nm, "_pre"}, 8'(get_pins()), 8'(pins_pre));
        bus.Fault_Gate = g;
        bus.Fault_Type = t;
        bus.Fault_Load = 1'b1;
        tick();
        bus.Fault_Load = 1'b0;
        check({nm, "_ack"}, 8'(bus.Fault_Ack), 8'(FAULT_EN));
        for (int k = 1; k <= DELAY + 1; k++) begin
            tick();
            if (k == 1) check({nm, "_ack_drop"}, 8'(bus.Fault_Ack), 8'h00);
            check({nm, "_pins"}, 8'(get_pins()), 8'((k >= DELAY + 1) ? flt_eff : pins_pre));
        end
    endtask

    initial begin
        vec_rec_t tbl[$];
        vec_rec_t steps[$];
        int       changes;

        // Hand-computed NOR results; bit g of pins is gate g (Pin1,4,10,13).
        tbl.push_back('{8'h00, 4'hF});
        tbl.push_back('{8'hFF, 4'h0});
        tbl.push_back('{8'h55, 4'h0});
        tbl.push_back('{8'hAA, 4'h0});
        tbl.push_back('{8'h1B, 4'h8});
        tbl.push_back('{8'hC0, 4'h7});
        tbl.push_back('{8'h30, 4'hB});
        tbl.push_back('{8'h0C, 4'hD});
        tbl.push_back('{8'h03, 4'hE});
        tbl.push_back('{8'h99, 4'h0});
        tbl.push_back('{8'h00, 4'hF});
        tbl.push_back('{8'h41, 4'h6});
        // Pin2/Pin3 walk 00, 01, 10, 11: Pin1 gives 1,0,0,0.
        steps.push_back('{8'h00, 4'hF});
        steps.push_back('{8'h02, 4'hE});
        steps.push_back('{8'h01, 4'hE});
        steps.push_back('{8'h03, 4'hE});

        // Reset held for 3 cycles against Enable and a fault strobe
        Reset          = 1'b0;
        bus.Enable     = 1'b1;
        bus.Fault_Load = 1'b1;
        bus.Fault_Gate = 2'd1;
        bus.Fault_Type = 2'b10;
        drive_vec(8'h00);
        repeat (3) tick();
        check("rst_active", 8'(bus.Active), 8'h00);
        check("rst_pins", 8'(get_pins()), 8'h00);
        check("rst_vcount", bus.Vec_Count, 8'h00);
        check("rst_ack", 8'(bus.Fault_Ack), 8'h00);
        Reset          = 1'b1;
        bus.Enable     = 1'b0;
        bus.Fault_Load = 1'b0;
        tick();
        check("off_active", 8'(bus.Active), 8'h00);

        // Power-up: Active and all-ones pins at cycle DELAY+1, not before
        bus.Enable = 1'b1;
        for (int n = 1; n <= DELAY + 2; n++) begin
            tick();
            check("pwrup_active", 8'(bus.Active), 8'((n >= DELAY + 1) ? 1 : 0));
            check("pwrup_pins", 8'(get_pins()), 8'((n >= DELAY + 1) ? 4'hF : 4'h0));
        end

        // Main function over the vector table
        stream("table_pins", tbl, 8'h00, changes);
        check("table_vcount", bus.Vec_Count, 8'(changes));

        // Power cycle, then the Pin2/Pin3 walk
        bus.Enable = 1'b0;
        tick();
        check("pwroff_active", 8'(bus.Active), 8'h00);
        check("pwroff_pins", 8'(get_pins()), 8'h00);
        bus.Enable = 1'b1;
        drive_vec(8'h00);
        wait_active("walk_reach_active");
        check("walk_vcount0", bus.Vec_Count, 8'h00);
        stream("walk_pins", steps, 8'h00, changes);
        check("walk_vcount", bus.Vec_Count, 8'h03);

        // Fault injection (pure NOR expected when faults are not built)
        fault_case("f_g2_stuck1", 2'd2, 2'b10, 8'hFF, 4'h0, 4'h4);
        fault_case("f_g3_stuck0", 2'd3, 2'b01, 8'h00, 4'hF, 4'h7);
        fault_case("f_g0_invert", 2'd0, 2'b11, 8'hC1, 4'h6, 4'h7);

        // Reset while Active clears outputs, counter and all faults
        Reset          = 1'b0;
        bus.Fault_Load = 1'b1;
        bus.Fault_Gate = 2'd1;
        bus.Fault_Type = 2'b10;
        tick();
        check("rst2_pins", 8'(get_pins()), 8'h00);
        check("rst2_active", 8'(bus.Active), 8'h00);
        check("rst2_ack", 8'(bus.Fault_Ack), 8'h00);
        check("rst2_vcount", bus.Vec_Count, 8'h00);
        Reset          = 1'b1;
        bus.Fault_Load = 1'b0;
        drive_vec(8'h00);
        wait_active("rst2_reach_active");
        check("rst2_clean_ones", 8'(get_pins()), 8'h0F);
        drive_vec(8'hFF);
        repeat (DELAY + 1) tick();
        check("rst2_clean_zeros", 8'(get_pins()), 8'h00);

        // Counter saturation, power-off and counter clear on re-enable
        for (int i = 0; i < 300; i++) begin
            drive_vec((i % 2 == 0) ? 8'h00 : 8'h01);
            tick();
        end
        check("sat_vcount", bus.Vec_Count, 8'hFF);
        bus.Enable = 1'b0;
        tick();
        check("sat_off_active", 8'(bus.Active), 8'h00);
        check("sat_off_pins", 8'(get_pins()), 8'h00);
        check("sat_off_vcount", bus.Vec_Count, 8'hFF);
        bus.Enable = 1'b1;
        drive_vec(8'h00);
        tick();
        check("reen_vcount", bus.Vec_Count, 8'h00);

        // Enable dropped mid-Settle returns to Off
        bus.Enable = 1'b0;
        tick();
        check("abort_active", 8'(bus.Active), 8'h00);
        check("abort_pins", 8'(get_pins()), 8'h00);

        // Input change on the Settle->Active edge is not counted
        bus.Enable = 1'b1;
        tick();
        repeat (DELAY - 1) tick();
        drive_vec(8'h01);
        tick();
        check("edge_active", 8'(bus.Active), 8'h01);
        check("edge_vcount", bus.Vec_Count, 8'h00);
        check("edge_pins_fresh", 8'(get_pins()), 8'h0F);
        repeat (DELAY - 1) tick();
        check("edge_vcount_hold", bus.Vec_Count, 8'h00);
        tick();
        check("edge_pins_new", 8'(get_pins()), 8'h0E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
